// File: rtl/input_debouncer.sv
// input_debouncer: synchronizes a raw level and filters short pulses.
// Drives a clean level, edge strobes and a saturating glitch count.
module input_debouncer #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             enable,
    input  logic             glitch_clr,
    output logic             d,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] glitch_cnt
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] ONE = CW'(1);
    localparam logic [CNT_W-1:0] GMAX = '1;

    typedef enum logic [1:0] {
        LOW,
        CHK_HI,
        HIGH,
        CHK_LO
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          s1;
    logic          s2;
    logic          d_nxt;
    logic          rise_nxt;
    logic          fall_nxt;
    logic          reject;

    // Two-flop synchronizer, free running regardless of enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
        end
    end

    // State, stability counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= LOW;
            cnt   <= '0;
            d     <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            d     <= d_nxt;
            rise  <= rise_nxt;
            fall  <= fall_nxt;
        end
    end

    // Next-state logic: count equal samples of s2 until the level is accepted.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        d_nxt     = d;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        reject    = 1'b0;
        unique case (state)
            LOW: begin
                if (enable && s2) begin
                    state_nxt = CHK_HI;
                    cnt_nxt   = ONE;
                end
            end
            CHK_HI: begin
                if (!enable) begin
                    state_nxt = LOW;
                    cnt_nxt   = '0;
                end else if (!s2) begin
                    state_nxt = LOW;
                    cnt_nxt   = '0;
                    reject    = 1'b1;
                end else if (cnt == LAST) begin
                    state_nxt = HIGH;
                    cnt_nxt   = '0;
                    d_nxt     = 1'b1;
                    rise_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + ONE;
                end
            end
            HIGH: begin
                if (enable && !s2) begin
                    state_nxt = CHK_LO;
                    cnt_nxt   = ONE;
                end
            end
            CHK_LO: begin
                if (!enable) begin
                    state_nxt = HIGH;
                    cnt_nxt   = '0;
                end else if (s2) begin
                    state_nxt = HIGH;
                    cnt_nxt   = '0;
                    reject    = 1'b1;
                end else if (cnt == LAST) begin
                    state_nxt = LOW;
                    cnt_nxt   = '0;
                    d_nxt     = 1'b0;
                    fall_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + ONE;
                end
            end
        endcase
    end

    // Saturating glitch counter; a clear beats a same-cycle rejection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            glitch_cnt <= '0;
        end else if (glitch_clr) begin
            glitch_cnt <= '0;
        end else if (reject && glitch_cnt != GMAX) begin
            glitch_cnt <= glitch_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: directed and random checks of input_debouncer.
// A run-length reference model feeds an expected-value queue per cycle.
module tb_input_debouncer;

    localparam int S    = 4;
    localparam int CW   = 8;
    localparam int GMAX = 255;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          din = 1'b0;
    logic          enable = 1'b1;
    logic          glitch_clr = 1'b0;
    logic          d;
    logic          rise;
    logic          fall;
    logic [CW-1:0] glitch_cnt;

    input_debouncer #(
        .STABLE_CYCLES(S),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .din(din),
        .enable(enable),
        .glitch_clr(glitch_clr),
        .d(d),
        .rise(rise),
        .fall(fall),
        .glitch_cnt(glitch_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic d;
        logic r;
        logic f;
        int   gc;
    } exp_t;

    exp_t q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int fall_cyc = 0;
    int n_rise = 0;
    int n_fall = 0;

    logic m_s1, m_s2, m_d, m_rise, m_fall;
    int   m_run, m_gc;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = 1'b0;
        m_s2 = 1'b0;
        m_d = 1'b0;
        m_rise = 1'b0;
        m_fall = 1'b0;
        m_run = 0;
        m_gc = 0;
        q.delete();
    endtask

    // Run length of synchronized samples that differ from the output level.
    task automatic model_step(input logic di, input logic en, input logic cl);
        logic smp;
        logic rej;
        smp = m_s2;
        rej = 1'b0;
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (en) begin
            if (smp != m_d) begin
                m_run++;
                if (m_run == S) begin
                    m_d = smp;
                    m_rise = smp;
                    m_fall = !smp;
                    m_run = 0;
                end
            end else if (m_run > 0) begin
                rej = 1'b1;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        if (cl) m_gc = 0;
        else if (rej && m_gc < GMAX) m_gc++;
        m_s2 = m_s1;
        m_s1 = di;
    endtask

    task automatic step(input logic di, input logic en, input logic cl);
        exp_t e;
        din = di;
        enable = en;
        glitch_clr = cl;
        model_step(di, en, cl);
        q.push_back('{m_d, m_rise, m_fall, m_gc});
        @(posedge clk);
        #1;
        cyc++;
        if (rise) begin
            rise_cyc = cyc;
            n_rise++;
        end
        if (fall) begin
            fall_cyc = cyc;
            n_fall++;
        end
        e = q.pop_front();
        chk("d", 32'(d), 32'(e.d));
        chk("rise", 32'(rise), 32'(e.r));
        chk("fall", 32'(fall), 32'(e.f));
        chk("glitch_cnt", 32'(glitch_cnt), 32'(e.gc));
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            chk("rst_d", 32'(d), 0);
            chk("rst_rise", 32'(rise), 0);
            chk("rst_fall", 32'(fall), 0);
            chk("rst_gc", 32'(glitch_cnt), 0);
        end
        reset = 1'b1;
    endtask

    task automatic glitch(input logic clr_last);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, clr_last);
    endtask

    initial begin
        int base;
        int nr;
        int nf;
        int gc0;
        logic v;
        logic en;
        logic cl;
        int len;

        din = 1'b1;
        #1;
        do_reset(3);
        base = cyc;
        nr = n_rise;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0);
        chk("rst_rise_at", 32'(rise_cyc - base), 6);
        chk("rst_rise_cnt", 32'(n_rise - nr), 1);

        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0);
        base = cyc;
        nf = n_fall;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0);
        chk("clean_rise_at", 32'(rise_cyc - base), 6);
        chk("clean_no_fall", 32'(n_fall - nf), 0);
        chk("clean_d", 32'(d), 1);

        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0);
        nr = n_rise;
        glitch(1'b0);
        chk("glitch_one", 32'(glitch_cnt), 1);
        chk("glitch_no_rise", 32'(n_rise - nr), 0);
        chk("glitch_d", 32'(d), 0);
        for (int i = 0; i < 4; i++) glitch(1'b0);
        chk("glitch_five", 32'(glitch_cnt), 5);
        glitch(1'b1);
        chk("clr_prio", 32'(glitch_cnt), 0);
        step(1'b0, 1'b1, 1'b0);
        chk("clr_hold", 32'(glitch_cnt), 0);

        for (int i = 0; i < 300; i++) glitch(1'b0);
        chk("glitch_sat", 32'(glitch_cnt), GMAX);
        step(1'b0, 1'b1, 1'b1);
        chk("sat_clr", 32'(glitch_cnt), 0);

        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0);
        chk("thr_fall_gap", 32'(fall_cyc - rise_cyc), 4);
        chk("thr_gc", 32'(glitch_cnt), 0);
        nr = n_rise;
        glitch(1'b0);
        chk("thr3_reject", 32'(glitch_cnt), 1);
        chk("thr3_no_rise", 32'(n_rise - nr), 0);

        gc0 = int'(glitch_cnt);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        base = cyc;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0);
        chk("abort_rise_at", 32'(rise_cyc - base), 4);
        chk("abort_gc", 32'(glitch_cnt), 32'(gc0));

        nf = n_fall;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_d", 32'(d), 0);
        chk("mid_rst_fall", 32'(fall), 0);
        do_reset(2);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0);
        chk("mid_rst_no_fall", 32'(n_fall - nf), 0);

        while (cyc < 2600) begin
            v = 1'($urandom_range(1, 0));
            len = $urandom_range(7, 1);
            for (int i = 0; i < len; i++) begin
                en = ($urandom_range(9, 0) != 0);
                cl = ($urandom_range(40, 0) == 0);
                step(v, en, cl);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
